// File: rtl/imem_load_arbiter.sv
// Instruction-memory port arbiter: the fetch unit owns the single memory port
// in RUN, the program loader owns it in LOAD, and FLUSH holds the core in
// reset for a fixed window so that execution restarts from word 0.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | fetch_addr drives memory, loader inputs ignored
// ST_LOAD  | core stalled, loader words written at consecutive addresses
// ST_FLUSH | last write drains, cpu_reset_req held for RST_CYCLES cycles
`timescale 1ns/1ps

module imem_load_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 50_000_000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [31:0]       o_fetch_instr,
  output logic              o_cpu_stall,
  output logic              o_cpu_reset_req,
  input  logic              i_ld_start,
  input  logic              i_ld_valid,
  input  logic [31:0]       i_ld_word,
  output logic              o_ld_ready,
  input  logic              i_ld_done,
  output logic [ADDR_W:0]   o_ld_count,
  output logic              o_ld_overflow,
  output logic              o_ld_timeout,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_we,
  input  logic [31:0]       i_mem_rdata,
  output logic [1:0]        o_mode
);

  localparam int                IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [3:0]        RST_LAST  = 4'(RST_CYCLES - 1);
  localparam logic [ADDR_W:0]   PTR_ONE   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // wr_ptr doubles as the load word count: both clear on LOAD entry and step
  // together on every accepted word, and the count must hold after the load.
  logic [ADDR_W:0]   r_wr_ptr;
  logic              r_ld_overflow;
  logic              r_ld_timeout;
  logic [IDLE_W-1:0] r_idle;
  logic [3:0]        r_rst_cnt;
  logic              r_wr_pend;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;

  logic w_ld_ready;
  logic w_xfer;
  logic w_stall;
  logic w_enter_load;
  logic w_enter_flush;
  logic w_timeout_hit;

  // State register; synchronous reset always lands in RUN.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_RUN;
    else         r_state <= w_next;
  end

  // Next-state and per-state control decode.
  always_comb begin
    w_next        = r_state;
    w_ld_ready    = 1'b0;
    w_xfer        = 1'b0;
    w_stall       = 1'b0;
    w_enter_load  = 1'b0;
    w_enter_flush = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_ld_start) begin
          w_next       = ST_LOAD;
          w_enter_load = 1'b1;
        end
      end
      ST_LOAD: begin
        w_stall    = 1'b1;
        // top bit of wr_ptr set means 2^ADDR_W words already taken
        w_ld_ready = ~r_wr_ptr[ADDR_W];
        w_xfer     = i_ld_valid & w_ld_ready;
        if (i_ld_done) begin
          w_next        = ST_FLUSH;
          w_enter_flush = 1'b1;
        end else if (!w_xfer && (r_idle == IDLE_LAST)) begin
          w_next        = ST_FLUSH;
          w_enter_flush = 1'b1;
          w_timeout_hit = 1'b1;
        end
      end
      ST_FLUSH: begin
        w_stall = 1'b1;
        if (r_rst_cnt == 4'd0) w_next = ST_RUN;
      end
      default: w_next = ST_RUN;
    endcase
  end

  // Load datapath: write pointer, sticky flags, idle timer, reset window and
  // the one-cycle registered write stage.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr      <= '0;
      r_ld_overflow <= 1'b0;
      r_ld_timeout  <= 1'b0;
      r_idle        <= '0;
      r_rst_cnt     <= 4'd0;
      r_wr_pend     <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= 32'h0;
    end else begin
      r_wr_pend <= w_xfer;
      if (w_xfer) begin
        r_wr_addr <= r_wr_ptr[ADDR_W-1:0];
        r_wr_data <= i_ld_word;
      end

      if (w_enter_load) begin
        r_wr_ptr      <= '0;
        r_ld_overflow <= 1'b0;
        r_ld_timeout  <= 1'b0;
        r_idle        <= '0;
      end else if (r_state == ST_LOAD) begin
        if (w_xfer) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
          r_idle   <= '0;
        end else begin
          r_idle <= r_idle + IDLE_ONE;
        end
        // words offered past the end are dropped, never wrapped to 0
        if (i_ld_valid && r_wr_ptr[ADDR_W]) r_ld_overflow <= 1'b1;
        if (w_timeout_hit)                   r_ld_timeout  <= 1'b1;
      end

      if (w_enter_flush)                                r_rst_cnt <= RST_LAST;
      else if (r_state == ST_FLUSH && r_rst_cnt != 4'd0) r_rst_cnt <= r_rst_cnt - 4'd1;
    end
  end

  // Memory port mux: fetch in RUN, pending write first otherwise.
  always_comb begin
    o_mem_addr = r_wr_ptr[ADDR_W-1:0];
    if (r_state == ST_RUN) o_mem_addr = i_fetch_addr;
    else if (r_wr_pend)    o_mem_addr = r_wr_addr;
  end

  assign o_mem_we        = r_wr_pend;
  assign o_mem_wdata     = r_wr_data;
  assign o_fetch_instr   = (r_state == ST_RUN) ? i_mem_rdata : 32'h0000_0000;
  assign o_cpu_stall     = w_stall;
  // gated by reset so the core sees the request drop in the reset cycle itself
  assign o_cpu_reset_req = (r_state == ST_FLUSH) & ~i_reset;
  assign o_ld_ready      = w_ld_ready;
  assign o_ld_count      = r_wr_ptr;
  assign o_ld_overflow   = r_ld_overflow;
  assign o_ld_timeout    = r_ld_timeout;
  assign o_mode          = r_state;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter with a small memory (8 words) and a
// short idle timeout so overflow and timeout paths are reachable quickly.
`timescale 1ns/1ps

module tb_imem_load_arbiter;
  localparam int AW = 3;
  localparam int RC = 4;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] fetch_addr;
  logic [31:0]   fetch_instr;
  logic          cpu_stall;
  logic          cpu_reset_req;
  logic          ld_start;
  logic          ld_valid;
  logic [31:0]   ld_word;
  logic          ld_ready;
  logic          ld_done;
  logic [AW:0]   ld_count;
  logic          ld_overflow;
  logic          ld_timeout;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic [1:0]    mode;

  logic [31:0] mem [0:7];
  int n_vec = 0;
  int n_err = 0;

  imem_load_arbiter #(.ADDR_W(AW), .RST_CYCLES(RC), .TIMEOUT(TO)) dut (
    .i_clock(clk), .i_reset(reset),
    .i_fetch_addr(fetch_addr), .o_fetch_instr(fetch_instr),
    .o_cpu_stall(cpu_stall), .o_cpu_reset_req(cpu_reset_req),
    .i_ld_start(ld_start), .i_ld_valid(ld_valid), .i_ld_word(ld_word),
    .o_ld_ready(ld_ready), .i_ld_done(ld_done), .o_ld_count(ld_count),
    .o_ld_overflow(ld_overflow), .o_ld_timeout(ld_timeout),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata), .o_mode(mode)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory model, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mode(input logic [1:0] m, input string tag);
    int n = 0;
    while (mode !== m && n < 50) begin
      step();
      n++;
    end
    chk(tag, mode, m);
  endtask

  initial begin
    int cnt;
    int n;
    reset = 1'b1; fetch_addr = '0; ld_start = 1'b0; ld_valid = 1'b0;
    ld_word = 32'h0; ld_done = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    mem[5] = 32'h2008_0001;
    step(); step();

    // reset state
    chk("rst_mode", mode, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_reset_req", cpu_reset_req, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ld_count", ld_count, 0);
    chk("rst_flags", {ld_overflow, ld_timeout}, 0);

    // RUN fetch passthrough
    reset = 1'b0;
    fetch_addr = 3'd5;
    #1 chk("run_mem_addr", mem_addr, 5);
    step();
    chk("run_fetch_instr", fetch_instr, 32'h2008_0001);
    chk("run_stall", cpu_stall, 0);
    chk("run_mem_we", mem_we, 0);

    // three-word load, done on a separate cycle
    ld_start = 1'b1; step(); ld_start = 1'b0;
    chk("ld_mode", mode, 1);
    chk("ld_stall", cpu_stall, 1);
    chk("ld_ready", ld_ready, 1);
    chk("ld_fetch_nop", fetch_instr, 0);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_word = 32'hAAAA_0001 + i;
      step();
      chk("ld3_we", mem_we, 1);
      chk("ld3_addr", mem_addr, i);
      chk("ld3_wdata", mem_wdata, 32'hAAAA_0001 + i);
    end
    ld_valid = 1'b0; ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    chk("ld3_flush_mode", mode, 2);
    chk("ld3_count", ld_count, 3);
    chk("ld3_flush_we", mem_we, 0);
    cnt = 0;
    for (int i = 0; i < 20 && cpu_reset_req; i++) begin
      cnt++;
      step();
    end
    chk("ld3_rstreq_cycles", cnt, RC);
    chk("ld3_back_run", mode, 0);
    chk("ld3_stall_drop", cpu_stall, 0);
    chk("ld3_count_hold", ld_count, 3);
    fetch_addr = 3'd1;
    step();
    chk("ld3_fetch_a1", fetch_instr, 32'hAAAA_0002);
    chk("ld3_mem0", mem[0], 32'hAAAA_0001);
    chk("ld3_mem2", mem[2], 32'hAAAA_0003);

    // ld_done together with the second word
    ld_start = 1'b1; step(); ld_start = 1'b0;
    ld_valid = 1'b1; ld_word = 32'hBBBB_0001; step();
    ld_word = 32'hBBBB_0002; ld_done = 1'b1; step();
    ld_valid = 1'b0; ld_done = 1'b0;
    chk("done2_mode", mode, 2);
    chk("done2_we", mem_we, 1);
    chk("done2_addr", mem_addr, 1);
    chk("done2_wdata", mem_wdata, 32'hBBBB_0002);
    chk("done2_count", ld_count, 2);
    wait_mode(2'd0, "done2_run");
    chk("done2_mem1", mem[1], 32'hBBBB_0002);

    // overflow: nine words into eight slots
    ld_start = 1'b1; step(); ld_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ld_valid = 1'b1; ld_word = 32'hCCCC_0000 + i;
      #1 chk("ovf_ready", ld_ready, (i < 8) ? 1 : 0);
      step();
    end
    ld_valid = 1'b0;
    chk("ovf_flag", ld_overflow, 1);
    chk("ovf_count", ld_count, 8);
    chk("ovf_no_write", mem_we, 0);
    ld_done = 1'b1; step(); ld_done = 1'b0;
    wait_mode(2'd0, "ovf_run");
    chk("ovf_mem0", mem[0], 32'hCCCC_0000);
    chk("ovf_mem7", mem[7], 32'hCCCC_0007);
    chk("ovf_sticky", ld_overflow, 1);

    // idle timeout after one word
    ld_start = 1'b1; step(); ld_start = 1'b0;
    chk("to_ovf_cleared", ld_overflow, 0);
    ld_valid = 1'b1; ld_word = 32'hDDDD_0001; step();
    ld_valid = 1'b0;
    n = 0;
    while (mode == 2'd1 && n < 40) begin
      step();
      n++;
    end
    chk("to_idle_cycles", n, TO);
    chk("to_flag", ld_timeout, 1);
    chk("to_mode", mode, 2);
    chk("to_reset_req", cpu_reset_req, 1);
    chk("to_count", ld_count, 1);

    // reset during FLUSH drops cpu_reset_req at once
    reset = 1'b1;
    #1 chk("flush_rst_req_drop", cpu_reset_req, 0);
    step();
    reset = 1'b0;
    chk("flush_rst_mode", mode, 0);
    chk("flush_rst_flag", ld_timeout, 0);

    // reset during LOAD cancels the write that would have been pending
    ld_start = 1'b1; step(); ld_start = 1'b0;
    ld_valid = 1'b1; ld_word = 32'hEEEE_0001; step();
    chk("lrst_pend_we", mem_we, 1);
    ld_word = 32'hEEEE_0002; reset = 1'b1;
    step();
    reset = 1'b0; ld_valid = 1'b0;
    chk("lrst_we", mem_we, 0);
    chk("lrst_mode", mode, 0);
    chk("lrst_stall", cpu_stall, 0);
    chk("lrst_count", ld_count, 0);
    step();
    chk("lrst_mem0", mem[0], 32'hEEEE_0001);
    chk("lrst_mem1", mem[1], 32'hCCCC_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Owns the single port of the instruction memory and shares it between the fetch unit and a UART program loader.
- RUN mode: the fetch unit's word address passes straight to memory.
- LOAD mode: fetch is stalled; incoming 32-bit words are written at consecutive addresses from 0.
- After a load the block pulses a CPU reset request so execution restarts at PC 0.

Parameters:
- ADDR_W, 14, instruction-memory word-address width (PC[15:2]).
- RST_CYCLES, 4, cycles cpu_reset_req stays high after a load completes (1..15).
- TIMEOUT, 50_000_000, idle cycles in LOAD with no accepted word before the load aborts.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; returns the block to RUN.
- fetch_addr  in  ADDR_W  word address from the fetch unit.
- fetch_instr  out  32  instruction returned to the fetch unit.
- cpu_stall  out  1  holds the PC while high.
- cpu_reset_req  out  1  active-high reset request to the core.
- ld_start  in  1  single-cycle request to enter LOAD.
- ld_valid  in  1  loader word valid.
- ld_word  in  32  loader data.
- ld_ready  out  1  block accepts ld_word this cycle.
- ld_done  in  1  single-cycle end-of-image marker.
- ld_count  out  ADDR_W+1  words written in the current or last load.
- ld_overflow  out  1  sticky: image exceeded 2^ADDR_W words.
- ld_timeout  out  1  sticky: last load aborted by timeout.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  synchronous-read memory data, valid 1 cycle after the address.
- mode  out  2  current state: 0=RUN, 1=LOAD, 2=FLUSH.

Behaviour:
- Reset values:
  - state RUN; cpu_stall=0; cpu_reset_req=0; ld_ready=0; mem_we=0; mem_wdata=0.
  - wr_ptr=0; ld_count=0; ld_overflow=0; ld_timeout=0; idle counter 0.
- Memory contents are never touched by reset.
- RUN:
  - mem_addr=fetch_addr (combinational); mem_we=0.
  - fetch_instr=mem_rdata, so the arbiter adds zero latency.
  - ld_valid and ld_done are ignored.
  - ld_start=1 -> LOAD next cycle. On entry: wr_ptr=0, ld_count=0, both sticky flags cleared, idle counter cleared.
- LOAD:
  - cpu_stall=1; fetch_instr=32'h0000_0000 (nop).
  - ld_ready=1 while wr_ptr < 2^ADDR_W.
  - Transfer occurs when ld_valid && ld_ready.
  - The cycle after a transfer: mem_we=1, mem_addr=previous wr_ptr, mem_wdata=captured word. Writes are registered, one cycle.
  - On each transfer: wr_ptr+1, ld_count+1, idle counter cleared.
  - When no write is pending, mem_addr=wr_ptr[ADDR_W-1:0].
  - Full: when wr_ptr == 2^ADDR_W, ld_ready=0. A further ld_valid sets ld_overflow and drops the word; nothing wraps to address 0.
  - ld_done -> FLUSH. If ld_valid && ld_ready in the same cycle, that word is accepted and its write still issues in the first FLUSH cycle.
  - Idle counter increments each cycle without a transfer. Reaching TIMEOUT-1 sets ld_timeout and goes to FLUSH.
  - ld_start during LOAD is ignored.
- FLUSH:
  - cpu_stall=1; ld_ready=0; cpu_reset_req=1 for exactly RST_CYCLES cycles, counted by an internal counter.
  - Then RUN, with cpu_reset_req and cpu_stall dropping on the same edge.
  - ld_start and ld_valid are ignored.
- ld_count holds its value after the load until the next entry to LOAD.
- Reset asserted mid-LOAD or mid-FLUSH:
  - Next cycle is RUN; any pending write is cancelled (mem_we=0).
  - cpu_reset_req deasserts immediately.
- mode is the registered state encoding.

Test Plan:
- Reset, then in RUN drive fetch_addr=5 with mem preloaded 0x2008_0001 at word 5 -> fetch_instr=0x2008_0001 one cycle later; cpu_stall=0, mem_we=0.
- ld_start pulse, stream 3 words 0xAAAA_0001..3 back-to-back, then ld_done -> writes to addresses 0,1,2 on consecutive cycles; ld_count=3; cpu_reset_req high exactly 4 cycles; then mode=0 and fetch of address 1 returns 0xAAAA_0002.
- ld_valid and ld_done high in the same cycle as the 2nd word -> both words written, ld_count=2, FLUSH entered.
- ADDR_W=3, push 9 words -> first 8 written to 0..7, ld_ready=0 after the 8th, ld_overflow=1, word 0 not overwritten.
- TIMEOUT=20: ld_start, one word, then silence -> ld_timeout=1 after 20 idle cycles, FLUSH/cpu_reset_req follows, ld_count=1.
- Assert reset 2 cycles into LOAD with a write pending -> mem_we=0 next cycle, mode=0, cpu_stall=0, ld_count=0.
